// File: rtl/usb_fs_phy_tx.sv
// Full-speed USB transmit PHY: UTMI byte handshake in, SYNC + LSB-first
// bit-stuffed NRZI data + EOP out on the D+/D- pads (4 clocks per bit at 48 MHz).
//
// Ports:
//   clk_i            48 MHz clock
//   rst_i            asynchronous active-high reset
//   utmi_data_out_i  byte to transmit
//   utmi_txvalid_i   host has a byte / packet in progress
//   utmi_txready_o   byte accepted this clock (combinational)
//   bus_reset_i      (only with USB_FS_TX_BUS_RESET_EN) drive SE0 while idle
//   usb_dp_o/dn_o    registered pad drive values
//   usb_oe_o         registered pad output enable
//   tx_active_o      registered, high from SYNC start to EOP end
//
// Optional feature macro: USB_FS_TX_BUS_RESET_EN
module usb_fs_phy_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] utmi_data_out_i,
    input  logic       utmi_txvalid_i,
    output logic       utmi_txready_o,
`ifdef USB_FS_TX_BUS_RESET_EN
    input  logic       bus_reset_i,
`endif
    output logic       usb_dp_o,
    output logic       usb_dn_o,
    output logic       usb_oe_o,
    output logic       tx_active_o
);

    localparam int unsigned       PHASE_W    = $clog2(CLKS_PER_BIT);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        SYNC_BYTE  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [7:0]          shift_q, shift_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic [2:0]          stuff_q, stuff_d;
    logic                line_q, line_d;
    logic                full_q, full_d;
    logic [7:0]          hold_q, hold_d;
    logic                dp_q, dp_d, dn_q, dn_d, oe_q, oe_d, act_q, act_d;
`ifdef USB_FS_TX_BUS_RESET_EN
    logic                br_pend_q, br_pend_d;
`endif

    logic tx_fire;
    logic bit_end;
    logic start;
    logic take;
    logic data_bit;
    logic emit;
    logic emit_bit;

    assign utmi_txready_o = utmi_txvalid_i & ~full_q &
                            ((state_q == ST_SYNC) | (state_q == ST_DATA));
    assign tx_fire = utmi_txvalid_i & utmi_txready_o;
    assign bit_end = (phase_q == PHASE_LAST);

    assign usb_dp_o    = dp_q;
    assign usb_dn_o    = dn_q;
    assign usb_oe_o    = oe_q;
    assign tx_active_o = act_q;

    // Next-state, next-bit and registered-output computation
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + PHASE_W'(1);
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        stuff_d  = stuff_q;
        line_d   = line_q;
        full_d   = full_q;
        hold_d   = hold_q;
        dp_d     = dp_q;
        dn_d     = dn_q;
        oe_d     = oe_q;
        act_d    = act_q;
        start    = 1'b0;
        take     = 1'b0;
        data_bit = 1'b1;
        emit     = 1'b0;
        emit_bit = 1'b1;
`ifdef USB_FS_TX_BUS_RESET_EN
        br_pend_d = br_pend_q;
`endif

        if (tx_fire) begin
            hold_d = utmi_data_out_i;
            full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                phase_d  = '0;
                line_d   = 1'b1;
                dp_d     = 1'b1;
                dn_d     = 1'b0;
                oe_d     = 1'b0;
                act_d    = 1'b0;
                stuff_d  = '0;
                full_d   = 1'b0;
                bitcnt_d = '0;
`ifdef USB_FS_TX_BUS_RESET_EN
                // Bus reset owns the idle line: SE0 while held, then one J bit time
                if (bus_reset_i) begin
                    dp_d      = 1'b0;
                    oe_d      = 1'b1;
                    br_pend_d = 1'b1;
                end else if (br_pend_q) begin
                    oe_d    = 1'b1;
                    phase_d = phase_q + PHASE_W'(1);
                    if (bit_end) begin
                        br_pend_d = 1'b0;
                    end
                end else begin
                    start = utmi_txvalid_i;
                end
`else
                start = utmi_txvalid_i;
`endif
                // First SYNC bit goes on the pads on the same edge the FSM leaves IDLE
                if (start) begin
                    state_d  = ST_SYNC;
                    shift_d  = {1'b0, SYNC_BYTE[7:1]};
                    bitcnt_d = 4'd1;
                    oe_d     = 1'b1;
                    act_d    = 1'b1;
                    emit     = 1'b1;
                    emit_bit = SYNC_BYTE[0];
                end
            end

            ST_SYNC, ST_DATA: begin
                if (bit_end) begin
                    if ((state_q == ST_DATA) && (stuff_q == 3'd6)) begin
                        emit     = 1'b1;
                        emit_bit = 1'b0;
                        stuff_d  = '0;
                    end else if (bitcnt_q != 4'd8) begin
                        take     = 1'b1;
                        data_bit = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (full_q) begin
                        take     = 1'b1;
                        data_bit = hold_q[0];
                        shift_d  = {1'b0, hold_q[7:1]};
                        bitcnt_d = 4'd1;
                        full_d   = 1'b0;
                        state_d  = ST_DATA;
                    end else if (tx_fire) begin
                        // Byte handed over exactly at the boundary goes straight to the wire
                        take     = 1'b1;
                        data_bit = utmi_data_out_i[0];
                        shift_d  = {1'b0, utmi_data_out_i[7:1]};
                        bitcnt_d = 4'd1;
                        full_d   = 1'b0;
                        state_d  = ST_DATA;
                    end else begin
                        state_d  = ST_EOP_SE0;
                        dp_d     = 1'b0;
                        dn_d     = 1'b0;
                        bitcnt_d = '0;
                    end
                    if (take) begin
                        emit     = 1'b1;
                        emit_bit = data_bit;
                        stuff_d  = data_bit ? (stuff_q + 3'd1) : 3'd0;
                    end
                end
            end

            ST_EOP_SE0: begin
                if (bit_end) begin
                    if (bitcnt_q == 4'd1) begin
                        state_d = ST_EOP_J;
                        line_d  = 1'b1;
                        dp_d    = 1'b1;
                        dn_d    = 1'b0;
                    end else begin
                        bitcnt_d = 4'd1;
                    end
                end
            end

            ST_EOP_J: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    act_d   = 1'b0;
                    stuff_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // NRZI: a 0 toggles J/K, a 1 holds the line
        if (emit) begin
            line_d = emit_bit ? line_q : ~line_q;
            dp_d   = line_d;
            dn_d   = ~line_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            stuff_q  <= '0;
            line_q   <= 1'b1;
            full_q   <= 1'b0;
            hold_q   <= '0;
            dp_q     <= 1'b1;
            dn_q     <= 1'b0;
            oe_q     <= 1'b0;
            act_q    <= 1'b0;
`ifdef USB_FS_TX_BUS_RESET_EN
            br_pend_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            stuff_q  <= stuff_d;
            line_q   <= line_d;
            full_q   <= full_d;
            hold_q   <= hold_d;
            dp_q     <= dp_d;
            dn_q     <= dn_d;
            oe_q     <= oe_d;
            act_q    <= act_d;
`ifdef USB_FS_TX_BUS_RESET_EN
            br_pend_q <= br_pend_d;
`endif
        end
    end

endmodule
